// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction-cache responder.
// The slave modport is the cache's view; the master modport is the datapath/memory view.
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame read-only instruction cache.
// Hits are answered combinationally; misses run a blocking fill from memory.
module icache_responder #(
    parameter int NSETS = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic              CLK,
    input  logic              nRST,
    icache_responder_if.slave bus
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_reg;
    logic [31:0]        maddr_reg;
    logic [NSETS-1:0]   valid_reg;
    logic [TAG_W-1:0]   tag_mem  [NSETS];
    logic [31:0]        data_mem [NSETS];

    logic [31:0]        word_addr;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic               hit;
    logic               fill_done;

    assign word_addr = bus.imemaddr & 32'hFFFF_FFFC;
    assign req_tag   = word_addr[31:IDX_W+2];
    assign req_idx   = word_addr[IDX_W+1:2];
    assign fill_tag  = maddr_reg[31:IDX_W+2];
    assign fill_idx  = maddr_reg[IDX_W+1:2];

    assign hit       = (state_reg == IDLE) && bus.imemREN && valid_reg[req_idx]
                       && (tag_mem[req_idx] == req_tag);
    assign fill_done = (state_reg == FETCH) && !bus.iwait;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_mem[req_idx] : 32'h0;
    // Memory side depends only on registered state, never on iwait.
    assign bus.iREN     = (state_reg == FETCH);
    assign bus.iaddr    = (state_reg == FETCH) ? maddr_reg : 32'h0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= IDLE;
            maddr_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.imemREN && !hit) begin
                        maddr_reg <= word_addr;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (!bus.iwait)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NSETS; gi++) begin : g_frame
            always_ff @(posedge CLK) begin
                if (!nRST)
                    valid_reg[gi] <= 1'b0;
                else if (fill_done && (fill_idx == IDX_W'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    // A reset arriving mid-fill abandons the fill, so the write is gated by nRST.
    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.iload;
        end
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-fetch responder that sits on the far side of the PC unit's fetch port.
- Accepts imemaddr plus a read request, and returns ihit and the instruction word.
- Direct-mapped, one-word-per-frame cache, so ihit can be asserted in the same cycle on a hit.
- On a miss, runs a blocking fill from the memory-side port (iREN/iaddr/iwait/iload), then serves the hit.

Parameters:
- NSETS, 16, number of frames; power of two, ≥2.
- IDX_W, 4, index width = log2(NSETS).
- TAG_W, 26, tag width = 32 - IDX_W - 2.

Ports:
- CLK  input  1  single clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- imemREN  input  1  fetch request from the datapath.
- imemaddr  input  32  fetch byte address from the PC unit; bits [1:0] are ignored.
- ihit  output  1  fetch complete this cycle; imemload is valid.
- imemload  output  32  instruction word.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address, bits [1:0] = 0.
- iwait  input  1  memory busy; iload is valid when iwait=0 with iREN=1.
- iload  input  32  memory read data.

Behaviour:
- Address split:
  - tag = imemaddr[31:IDX_W+2]
  - idx = imemaddr[IDX_W+1:2]
- Storage: per frame, valid (1), tag (TAG_W), data (32).
- Reset (nRST=0 at a rising edge):
  - all valid bits cleared, state←IDLE, miss address register←0.
  - Tag and data arrays need not be cleared.
  - Outputs during and after reset until the next request: ihit=0, imemload=0, iREN=0, iaddr=0.
- State IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag).
  - On a hit: ihit=1 and imemload=data[idx] combinationally, in the same cycle (zero-cycle hit latency). No state change.
  - If imemREN=1 and not hit: ihit=0, and at the clock edge maddr←{imemaddr[31:2],2'b00} and state←FETCH.
  - If imemREN=0: ihit=0, imemload=0, iREN=0.
- State FETCH:
  - iREN=1, iaddr=maddr, ihit=0, imemload=0.
  - While iwait=1: hold state; iaddr stays stable.
  - When iwait=0 at the edge: write valid=1, tag/data from maddr and iload into frame maddr's index; state←IDLE.
  - The hit is served in the following IDLE cycle. Miss penalty = memory latency + 1 cycle; no same-cycle forwarding.
  - imemaddr/imemREN changes during FETCH are ignored; the fill always completes for maddr. If the new address differs, the IDLE re-check on the next cycle decides hit/miss.
- Conflict: a fill evicts the prior occupant of that index unconditionally.
- Reset mid-FETCH: the fill is abandoned, no frame is written, and iREN=0 from the cycle after the reset edge.
- No write path; the instruction cache is read-only. Self-modifying code is unsupported.
- iREN and iaddr are driven by registered state only; there is no combinational path from iwait to iREN.

Test Plan:
- Cold miss: reset, then imemREN=1, imemaddr=0x00000040, memory returns 0x8C220004 after 2 iwait cycles.
  - Required: iREN=1, iaddr=0x40 for 3 cycles.
  - Then one cycle later ihit=1, imemload=0x8C220004.
  - Total 4 cycles from request to ihit.
- Warm hit: repeat the 0x40 request → ihit=1 in the same cycle, iREN stays 0.
- Conflict eviction: fill 0x40 (idx 0), then 0x80 (idx 0, tag differs) with data 0x11111111, then re-request 0x40.
  - Required: a miss occurs and iREN reasserts with iaddr=0x40.
- Address change during FETCH:
  - Miss on 0x100; one cycle into FETCH, switch imemaddr to 0x104.
  - Required: the fill completes to 0x100, returns to IDLE, then misses on 0x104 (iaddr=0x104); ihit is never asserted with 0x100 data for 0x104.
- Reset mid-fill: assert nRST=0 during FETCH with iwait=1.
  - Required: iREN=0 next cycle, ihit=0.
  - A subsequent request to the same address misses (valid was cleared).
- Idle/byte offset:
  - imemREN=0 → ihit=0, imemload=0.
  - After filling 0x40, a request to 0x43 hits with the same data.
